// File: rtl/fifo_flagged_pkg.sv
// Shared helpers for the flagged FIFO: pointer-width derivation used by the top and its RAM.
package fifo_flagged_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

endpackage

// File: rtl/fifo_flagged_ram.sv
// Storage array for fifo_flagged: one write port, read port either combinational (FWFT) or registered.
module fifo_ram
  import fifo_flagged_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM       = 256,
  parameter int BITS      = clog2(NUM),
  parameter int SYNC_READ = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_enable,
  input  logic [BITS-1:0]  write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_enable,
  input  logic [BITS-1:0]  read_addr,
  output logic [WIDTH-1:0] read_data
);

  logic [WIDTH-1:0] mem [NUM];

  always_ff @(posedge clk) begin
    if (write_enable) mem[write_addr] <= write_data;
  end

  // The registered read port holds its last word until the next accepted read.
  generate
    if (SYNC_READ != 0) begin : g_sync_read
      always_ff @(posedge clk or posedge reset) begin
        if (reset)            read_data <= '0;
        else if (read_enable) read_data <= mem[read_addr];
      end
    end else begin : g_async_read
      logic unused_ports;
      assign unused_ports = ^{reset, read_enable};
      assign read_data    = mem[read_addr];
    end
  endgenerate

endmodule

// File: rtl/fifo_flagged.sv
// Same-clock FIFO using all NUM entries, with FWFT or registered read, threshold flags,
// exact occupancy, synchronous flush and sticky overflow/underflow flags.
module fifo_flagged
  import fifo_flagged_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM       = 256,
  parameter int BITS      = clog2(NUM),
  parameter int FWFT      = 1,
  parameter int AF_MARGIN = 4,
  parameter int AE_LEVEL  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_strobe,
  output logic             space_available,
  output logic [WIDTH-1:0] read_data,
  input  logic             read_strobe,
  output logic             data_available,
  output logic             read_valid,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [BITS:0]    count,
  output logic             werror,
  output logic             rerror
);

  typedef logic [BITS:0]   ptr_t;
  typedef logic [BITS+1:0] ext_t;

  ptr_t write_ptr;
  ptr_t read_ptr;
  logic read_valid_r;
  logic full;
  logic empty;
  logic write_accept;
  logic read_accept;
  ext_t free_entries;

  // The extra pointer bit tells a full ring from an empty one, so every entry is usable.
  assign empty = (write_ptr == read_ptr);
  assign full  = (write_ptr[BITS] != read_ptr[BITS]) &&
                 (write_ptr[BITS-1:0] == read_ptr[BITS-1:0]);

  assign space_available = !full;
  assign data_available  = !empty;

  // Flush wins over both strobes, so nothing is accepted in a flush cycle.
  assign write_accept = !flush && write_strobe && !full;
  assign read_accept  = !flush && read_strobe && !empty;

  assign free_entries = ext_t'(NUM) - ext_t'(count);
  assign almost_full  = (free_entries <= ext_t'(AF_MARGIN));
  assign almost_empty = (ext_t'(count) <= ext_t'(AE_LEVEL));

  assign read_valid = (FWFT != 0) ? data_available : read_valid_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_ptr    <= '0;
      read_ptr     <= '0;
      count        <= '0;
      werror       <= 1'b0;
      rerror       <= 1'b0;
      read_valid_r <= 1'b0;
    end else if (flush) begin
      write_ptr    <= '0;
      read_ptr     <= '0;
      count        <= '0;
      werror       <= 1'b0;
      rerror       <= 1'b0;
      read_valid_r <= 1'b0;
    end else begin
      if (write_accept) write_ptr <= write_ptr + ptr_t'(1);
      if (read_accept)  read_ptr  <= read_ptr + ptr_t'(1);
      if (write_accept && !read_accept)      count <= count + ptr_t'(1);
      else if (read_accept && !write_accept) count <= count - ptr_t'(1);
      if (write_strobe && full)  werror <= 1'b1;
      if (read_strobe && empty)  rerror <= 1'b1;
      read_valid_r <= read_accept;
    end
  end

  fifo_ram #(
    .WIDTH     (WIDTH),
    .NUM       (NUM),
    .BITS      (BITS),
    .SYNC_READ ((FWFT != 0) ? 0 : 1)
  ) u_ram (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_accept),
    .write_addr   (write_ptr[BITS-1:0]),
    .write_data   (write_data),
    .read_enable  (read_accept),
    .read_addr    (read_ptr[BITS-1:0]),
    .read_data    (read_data)
  );

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged: an 8-deep FWFT instance (a_) and an 8-deep registered-read instance (b_).
module tb_fifo_flagged;

  logic       clk;
  logic       reset;

  logic       a_flush, a_write_strobe, a_read_strobe;
  logic [7:0] a_write_data, a_read_data;
  logic       a_space_available, a_data_available, a_read_valid;
  logic       a_almost_full, a_almost_empty, a_werror, a_rerror;
  logic [3:0] a_count;

  logic       b_flush, b_write_strobe, b_read_strobe;
  logic [7:0] b_write_data, b_read_data;
  logic       b_space_available, b_data_available, b_read_valid;
  logic       b_almost_full, b_almost_empty, b_werror, b_rerror;
  logic [3:0] b_count;

  int checks;
  int failures;

  fifo_flagged #(.WIDTH(8), .NUM(8), .FWFT(1), .AF_MARGIN(4), .AE_LEVEL(4)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .write_data(a_write_data), .write_strobe(a_write_strobe),
    .space_available(a_space_available), .read_data(a_read_data),
    .read_strobe(a_read_strobe), .data_available(a_data_available),
    .read_valid(a_read_valid), .almost_full(a_almost_full),
    .almost_empty(a_almost_empty), .count(a_count),
    .werror(a_werror), .rerror(a_rerror)
  );

  fifo_flagged #(.WIDTH(8), .NUM(8), .FWFT(0), .AF_MARGIN(4), .AE_LEVEL(4)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .write_data(b_write_data), .write_strobe(b_write_strobe),
    .space_available(b_space_available), .read_data(b_read_data),
    .read_strobe(b_read_strobe), .data_available(b_data_available),
    .read_valid(b_read_valid), .almost_full(b_almost_full),
    .almost_empty(b_almost_empty), .count(b_count),
    .werror(b_werror), .rerror(b_rerror)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (a_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    checks++; if (a_space_available !== 1'b1) begin failures++; $display("FAIL reset_space got=%b exp=1", a_space_available); end
    checks++; if (a_data_available !== 1'b0) begin failures++; $display("FAIL reset_avail got=%b exp=0", a_data_available); end
    checks++; if (a_almost_empty !== 1'b1 || a_almost_full !== 1'b0) begin failures++; $display("FAIL reset_thresholds got ae=%b af=%b exp ae=1 af=0", a_almost_empty, a_almost_full); end
    checks++; if (a_werror !== 1'b0 || a_rerror !== 1'b0) begin failures++; $display("FAIL reset_errors got w=%b r=%b exp 0 0", a_werror, a_rerror); end
    checks++; if (b_read_valid !== 1'b0 || b_read_data !== 8'h00) begin failures++; $display("FAIL reset_b_read got valid=%b data=%h exp 0 00", b_read_valid, b_read_data); end
  endtask

  task automatic test_fwft_order();
    logic [7:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      a_write_data   = words[i];
      a_write_strobe = 1'b1;
      tick();
      if (i == 0) begin
        checks++; if (a_data_available !== 1'b1) begin failures++; $display("FAIL fwft_latency_avail got=%b exp=1", a_data_available); end
        checks++; if (a_read_data !== 8'h11) begin failures++; $display("FAIL fwft_latency_head got=%h exp=11", a_read_data); end
      end
    end
    a_write_strobe = 1'b0;
    checks++; if (a_count !== 4'd3) begin failures++; $display("FAIL fwft_count3 got=%0d exp=3", a_count); end
    a_read_strobe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (a_read_data !== words[i]) begin failures++; $display("FAIL fwft_pop%0d got=%h exp=%h", i, a_read_data, words[i]); end
      tick();
    end
    a_read_strobe = 1'b0;
    checks++; if (a_count !== 4'd0 || a_data_available !== 1'b0) begin failures++; $display("FAIL fwft_drained got count=%0d avail=%b exp 0 0", a_count, a_data_available); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 8; i++) begin
      a_write_data   = 8'h40 + 8'(i);
      a_write_strobe = 1'b1;
      tick();
      checks++; if (a_count !== 4'(i + 1)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", a_count, i + 1); end
      checks++; if (a_almost_full !== (i + 1 >= 4)) begin failures++; $display("FAIL fill_almost_full at %0d got=%b exp=%b", i + 1, a_almost_full, (i + 1 >= 4)); end
      checks++; if (a_almost_empty !== (i + 1 <= 4)) begin failures++; $display("FAIL fill_almost_empty at %0d got=%b exp=%b", i + 1, a_almost_empty, (i + 1 <= 4)); end
    end
    checks++; if (a_space_available !== 1'b0) begin failures++; $display("FAIL full_space got=%b exp=0", a_space_available); end
    checks++; if (a_werror !== 1'b0) begin failures++; $display("FAIL full_no_werror_yet got=%b exp=0", a_werror); end
    a_write_data = 8'hEE;
    tick();
    a_write_strobe = 1'b0;
    checks++; if (a_werror !== 1'b1 || a_count !== 4'd8) begin failures++; $display("FAIL overflow got werror=%b count=%0d exp 1 8", a_werror, a_count); end
    checks++; if (a_read_data !== 8'h40) begin failures++; $display("FAIL overflow_head got=%h exp=40", a_read_data); end
    // Full with both strobes: the pop goes through, the push is refused.
    a_flush = 1'b1; tick(); a_flush = 1'b0;
    checks++; if (a_werror !== 1'b0 || a_count !== 4'd0) begin failures++; $display("FAIL flush_after_full got werror=%b count=%0d exp 0 0", a_werror, a_count); end
    a_write_strobe = 1'b1;
    for (int i = 0; i < 8; i++) begin a_write_data = 8'h50 + 8'(i); tick(); end
    a_read_strobe = 1'b1;
    a_write_data  = 8'hFF;
    tick();
    a_write_strobe = 1'b0; a_read_strobe = 1'b0;
    checks++; if (a_count !== 4'd7 || a_werror !== 1'b1) begin failures++; $display("FAIL full_both got count=%0d werror=%b exp 7 1", a_count, a_werror); end
    checks++; if (a_read_data !== 8'h51) begin failures++; $display("FAIL full_both_head got=%h exp=51", a_read_data); end
    a_flush = 1'b1; tick(); a_flush = 1'b0;
  endtask

  task automatic test_underflow();
    a_read_strobe = 1'b1;
    tick();
    a_read_strobe = 1'b0;
    checks++; if (a_rerror !== 1'b1 || a_count !== 4'd0) begin failures++; $display("FAIL underflow got rerror=%b count=%0d exp 1 0", a_rerror, a_count); end
    tick();
    checks++; if (a_rerror !== 1'b1) begin failures++; $display("FAIL underflow_sticky got=%b exp=1", a_rerror); end
    a_flush = 1'b1; tick(); a_flush = 1'b0;
    checks++; if (a_rerror !== 1'b0) begin failures++; $display("FAIL underflow_flush got=%b exp=0", a_rerror); end
    // Empty with both strobes: the push goes through, the pop is refused.
    a_write_data = 8'h77; a_write_strobe = 1'b1; a_read_strobe = 1'b1;
    tick();
    a_write_strobe = 1'b0; a_read_strobe = 1'b0;
    checks++; if (a_count !== 4'd1 || a_rerror !== 1'b1 || a_read_data !== 8'h77) begin failures++; $display("FAIL empty_both got count=%0d rerror=%b head=%h exp 1 1 77", a_count, a_rerror, a_read_data); end
    a_flush = 1'b1; tick(); a_flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] model [$];
    for (int i = 0; i < 5; i++) begin
      a_write_data = 8'h60 + 8'(i); a_write_strobe = 1'b1;
      model.push_back(a_write_data);
      tick();
    end
    a_read_strobe = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_write_data = 8'h65 + 8'(i);
      checks++; if (a_read_data !== model[0]) begin failures++; $display("FAIL b2b_order%0d got=%h exp=%h", i, a_read_data, model[0]); end
      void'(model.pop_front());
      model.push_back(a_write_data);
      tick();
      checks++; if (a_count !== 4'd5) begin failures++; $display("FAIL b2b_count%0d got=%0d exp=5", i, a_count); end
    end
    a_write_strobe = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (a_read_data !== model[0]) begin failures++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, a_read_data, model[0]); end
      void'(model.pop_front());
      tick();
    end
    a_read_strobe = 1'b0;
    checks++; if (a_count !== 4'd0) begin failures++; $display("FAIL b2b_end_count got=%0d exp=0", a_count); end
  endtask

  task automatic test_registered_read();
    b_write_data = 8'hA5; b_write_strobe = 1'b1;
    tick();
    b_write_strobe = 1'b0;
    checks++; if (b_count !== 4'd1 || b_read_valid !== 1'b0) begin failures++; $display("FAIL reg_write got count=%0d valid=%b exp 1 0", b_count, b_read_valid); end
    b_read_strobe = 1'b1;
    tick();
    b_read_strobe = 1'b0;
    checks++; if (b_read_valid !== 1'b1 || b_read_data !== 8'hA5) begin failures++; $display("FAIL reg_read got valid=%b data=%h exp 1 a5", b_read_valid, b_read_data); end
    tick();
    checks++; if (b_read_valid !== 1'b0 || b_read_data !== 8'hA5) begin failures++; $display("FAIL reg_hold got valid=%b data=%h exp 0 a5", b_read_valid, b_read_data); end
    b_read_strobe = 1'b1;
    tick();
    b_read_strobe = 1'b0;
    checks++; if (b_read_valid !== 1'b0 || b_rerror !== 1'b1) begin failures++; $display("FAIL reg_underflow got valid=%b rerror=%b exp 0 1", b_read_valid, b_rerror); end
    b_flush = 1'b1; tick(); b_flush = 1'b0;
  endtask

  task automatic test_async_reset_and_flush();
    a_write_strobe = 1'b1;
    for (int i = 0; i < 8; i++) begin a_write_data = 8'h80 + 8'(i); tick(); end
    checks++; if (a_count !== 4'd8) begin failures++; $display("FAIL pre_reset_count got=%0d exp=8", a_count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (a_count !== 4'd0 || a_data_available !== 1'b0) begin failures++; $display("FAIL async_reset got count=%0d avail=%b exp 0 0", a_count, a_data_available); end
    tick();
    reset = 1'b0;
    a_write_data = 8'h99; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_write_strobe = 1'b0;
    checks++; if (a_count !== 4'd0 || a_data_available !== 1'b0 || a_werror !== 1'b0) begin failures++; $display("FAIL flush_write got count=%0d avail=%b werror=%b exp 0 0 0", a_count, a_data_available, a_werror); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    a_flush = 1'b0; a_write_strobe = 1'b0; a_read_strobe = 1'b0; a_write_data = 8'h00;
    b_flush = 1'b0; b_write_strobe = 1'b0; b_read_strobe = 1'b0; b_write_data = 8'h00;
    test_reset();
    test_fwft_order();
    test_fill_overflow();
    test_underflow();
    test_back_to_back();
    test_registered_read();
    test_async_reset_and_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
